quad_encoder_emulator: RTL and testbench

- Generates quadrature encoder signals A, B and index Z from commanded step moves. It is the transmit-side counterpart of the AMDC quadrature decoder.
- Used for hardware-in-the-loop and loopback testing: outputs drive encoder input pins, or feed a decoder instance directly.
- Accepts a move command (signed step count plus edge period) through a valid/ready handshake. Emits exactly |steps| quadrature edges and tracks single-revolution position to drive Z.

---
 rtl/quad_encoder_emulator.sv | 130 +++++++++++++
 tb/tb_quad_encoder_emulator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns signed step-move commands into A/B/Z
// encoder waveforms with a running step counter and single-revolution position.
module quad_encoder_emulator #(
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [31:0] cmd_steps,
  input  logic [31:0]        cmd_period,
  input  logic [31:0]        pulses_per_rev,
  input  logic               stop,
  output logic               A,
  output logic               B,
  output logic               Z,
  output logic signed [31:0] counter,
  output logic [31:0]        position,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [1:0]  phase;
  logic        dir;
  logic [31:0] remaining;
  logic [31:0] period;
  logic [31:0] timer;

  logic        accept;
  logic        edge_fire;
  logic [1:0]  next_phase;
  logic [31:0] next_pos;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD) ? 32'(MIN_PERIOD) : p;
  endfunction

  // 0x80000000 maps to magnitude 2^31, which fits the unsigned result.
  function automatic logic [31:0] step_magnitude(input logic signed [31:0] s);
    return s[31] ? (32'd0 - s) : s;
  endfunction

  // ppr == 0 makes top == all-ones, which yields natural 32-bit wrap.
  function automatic logic [31:0] pos_step(input logic [31:0] pos,
                                           input logic [31:0] ppr,
                                           input logic        down);
    logic [31:0] top;
    top = ppr - 32'd1;
    if (down) return (pos == 32'd0) ? top : pos - 32'd1;
    return (pos >= top) ? 32'd0 : pos + 32'd1;
  endfunction

  // Gray-coded phase index to {A,B}: 0=00, 1=10, 2=11, 3=01.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
    case (ph)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  assign accept     = (state == ST_IDLE) && cmd_valid;
  assign edge_fire  = (state == ST_RUN) && (timer == 32'd1);
  assign next_phase = dir ? (phase - 2'd1) : (phase + 2'd1);
  assign next_pos   = pos_step(position, pulses_per_rev, dir);
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= 2'd0;
      A        <= 1'b0;
      B        <= 1'b0;
      Z        <= 1'b1;
      counter  <= '0;
      position <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_steps == 32'sd0) done  <= 1'b1;
            else                     state <= ST_RUN;
          end
        end
        default: begin
          if (edge_fire) begin
            phase    <= next_phase;
            {A, B}   <= phase_to_ab(next_phase);
            counter  <= dir ? counter - 32'sd1 : counter + 32'sd1;
            position <= next_pos;
            Z        <= (next_pos == 32'd0);
            if (remaining == 32'd1) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          // An abort still lets a coincident edge through above.
          if (stop) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Move parameters only matter in RUN and are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      dir       <= cmd_steps[31];
      remaining <= step_magnitude(cmd_steps);
      period    <= clamp_period(cmd_period);
      timer     <= clamp_period(cmd_period);
    end else if (edge_fire) begin
      remaining <= remaining - 32'd1;
      timer     <= period;
    end else if (state == ST_RUN) begin
      timer <= timer - 32'd1;
    end
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Randomized bench for quad_encoder_emulator against an arithmetic model of
// edge count, quadrature phase, counter and position per move.
module tb_quad_encoder_emulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_steps = '0;
  logic [31:0] cmd_period = '0;
  logic [31:0] ppr = '0;
  logic        stop = 1'b0;
  logic        A, B, Z, busy, done;
  logic [31:0] counter, position;

  int n_vec = 0;
  int n_err = 0;

  // Model state at the start of the current move.
  longint m_phase = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_pos = '0;

  quad_encoder_emulator #(.MIN_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .pulses_per_rev(ppr),
    .stop(stop), .A(A), .B(B), .Z(Z), .counter(counter), .position(position),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ab_of(input longint ph);
    case (ph)
      0:       return 32'b00;
      1:       return 32'b10;
      2:       return 32'b11;
      default: return 32'b01;
    endcase
  endfunction

  function automatic logic [31:0] pos_after(input longint p0, input longint rev,
                                            input bit down, input longint e);
    if (e == 0) return 32'(p0);
    if (rev == 0) return down ? 32'(p0 - e) : 32'(p0 + e);
    if (!down) begin
      if (p0 >= rev) return 32'((e - 1) % rev);
      return 32'((p0 + e) % rev);
    end
    if (e <= p0) return 32'(p0 - e);
    return 32'((rev - ((e - p0) % rev)) % rev);
  endfunction

  task automatic check_model(input longint e, input bit down, input bit exp_busy, input bit exp_done);
    longint ph;
    logic [31:0] p;
    ph = down ? (((m_phase - e) % 4) + 4) % 4 : (m_phase + e) % 4;
    p  = pos_after(longint'(m_pos), longint'(ppr), down, e);
    check_eq("ab",       {30'd0, A, B}, ab_of(ph));
    check_eq("counter",  counter, down ? m_cnt - 32'(e) : m_cnt + 32'(e));
    check_eq("position", position, p);
    check_eq("z",        32'(Z), 32'(p == 32'd0));
    check_eq("busy",     32'(busy), 32'(exp_busy));
    check_eq("done",     32'(done), 32'(exp_done));
    check_eq("ready",    32'(cmd_ready), 32'(!exp_busy));
  endtask

  task automatic check_reset_state();
    check_eq("rst_ab",       {30'd0, A, B}, 32'd0);
    check_eq("rst_counter",  counter, 32'd0);
    check_eq("rst_position", position, 32'd0);
    check_eq("rst_z",        32'(Z), 32'd1);
    check_eq("rst_busy",     32'(busy), 32'd0);
    check_eq("rst_done",     32'(done), 32'd0);
    check_eq("rst_ready",    32'(cmd_ready), 32'd1);
    m_phase = 0;
    m_cnt   = '0;
    m_pos   = '0;
  endtask

  // Called at a negedge with the DUT idle. abort_at > 0 aborts at that edge
  // (stop or rst); noise keeps cmd_valid high with junk while busy.
  task automatic run_move(input logic [31:0] steps, input logic [31:0] period,
                          input longint abort_at, input bit abort_rst, input bit noise);
    bit     down;
    bit     did_rst;
    longint nsteps, per, end_n, e;
    logic [31:0] mag;
    down    = steps[31];
    mag     = down ? (32'd0 - steps) : steps;
    nsteps  = longint'(mag);
    per     = (period < 32'd2) ? 2 : longint'(period);
    end_n   = (nsteps == 0) ? 0 : nsteps * per;
    did_rst = 1'b0;
    if (abort_at > 0 && abort_at < end_n) begin
      end_n   = abort_at;
      did_rst = abort_rst;
    end
    if (end_n > 4000) begin
      n_vec++;
      n_err++;
      $display("FAIL budget: move of %0d cycles exceeds limit 4000", end_n);
      return;
    end
    check_eq("ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_steps  = steps;
    cmd_period = period;
    stop       = noise;
    for (longint n = 0; n <= end_n; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (did_rst && n == end_n) begin
        check_reset_state();
      end else begin
        e = (n / per < nsteps) ? n / per : nsteps;
        check_model(e, down, n < end_n, n == end_n);
      end
      if (n < end_n) begin
        cmd_valid  = noise;
        cmd_steps  = $urandom;
        cmd_period = $urandom_range(0, 3);
        stop       = !abort_rst && (abort_at == n + 1);
        rst        = abort_rst && (abort_at == n + 1);
      end
    end
    cmd_valid = 1'b0;
    stop      = 1'b0;
    rst       = 1'b0;
    if (!did_rst) begin
      e       = (end_n / per < nsteps) ? end_n / per : nsteps;
      m_pos   = pos_after(longint'(m_pos), longint'(ppr), down, e);
      m_cnt   = down ? m_cnt - 32'(e) : m_cnt + 32'(e);
      m_phase = down ? (((m_phase - e) % 4) + 4) % 4 : (m_phase + e) % 4;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      stop = $urandom_range(0, 1);
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_done",  32'(done), 32'd0);
      check_eq("idle_ready", 32'(cmd_ready), 32'd1);
    end
    stop = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    run_move(32'd4, 32'd5, 0, 1'b0, 1'b0);
    apply_reset();
    ppr = 32'd8;
    run_move(-32'sd3, 32'd2, 0, 1'b0, 1'b0);
    ppr = 32'd4;
    run_move(32'd10, 32'd3, 0, 1'b0, 1'b1);
    run_move(32'd5, 32'd0, 0, 1'b0, 1'b0);
    run_move(32'd100, 32'd3, 10, 1'b0, 1'b0);
    run_move(32'd0, 32'd7, 0, 1'b0, 1'b1);
    idle_gap(2);
    run_move(32'h8000_0000, 32'd2, 7, 1'b0, 1'b0);
    run_move(32'd5, 32'd4, 8, 1'b0, 1'b0);
    ppr = 32'd16;
    run_move(32'd10, 32'd2, 0, 1'b0, 1'b0);
    ppr = 32'd5;
    run_move(32'd3, 32'd2, 0, 1'b0, 1'b0);
    ppr = 32'd0;
    run_move(-32'sd4, 32'd2, 0, 1'b0, 1'b0);
    run_move(32'd1000, 32'd2, 51, 1'b1, 1'b1);

    for (int k = 0; k < 80; k++) begin
      logic [31:0] s;
      longint ab_at;
      bit use_rst;
      case ($urandom_range(0, 5))
        0:       ppr = 32'd0;
        1:       ppr = 32'd1;
        2:       ppr = 32'd4;
        3:       ppr = 32'd8;
        default: ppr = $urandom_range(2, 20);
      endcase
      s = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) s = 32'd0 - s;
      ab_at   = 0;
      use_rst = 1'b0;
      if ($urandom_range(0, 2) == 0) ab_at = $urandom_range(1, 80);
      if ($urandom_range(0, 9) == 0) begin
        s     = 32'h8000_0000;
        ab_at = $urandom_range(1, 30);
      end
      if (ab_at > 0 && $urandom_range(0, 7) == 0) use_rst = 1'b1;
      run_move(s, $urandom_range(0, 6), ab_at, use_rst, 1'($urandom_range(0, 1)));
      idle_gap($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
